// File: rtl/dcache_wbuf_pkg.sv
// Shared definitions for the dcache write buffer.
// Provides the default depth and line width, the entry record layout and
// the drain FSM state encoding.
package dcache_wbuf_pkg;

    localparam int DCACHE_WBUF_DEPTH = 4;
    localparam int DCACHELINE_WIDTH  = 128;
    localparam int WBUF_ADDR_W       = 32;
    localparam int WBUF_OFFS_W       = $clog2(DCACHELINE_WIDTH / 8);

    // One buffered line: tag, data, byte strobes and a valid flag.
    typedef struct packed {
        logic [WBUF_ADDR_W-WBUF_OFFS_W-1:0] tag;
        logic [DCACHELINE_WIDTH-1:0]        data;
        logic [DCACHELINE_WIDTH/8-1:0]      strb;
        logic                               valid;
    } wbuf_entry_t;

    // Drain FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_B = 2'd2
    } drain_state_e;

endpackage

// File: rtl/dcache_wbuf_byte_merge.sv
// Byte-wise merge of a new store into an existing line.
// Ports:
//   old_data/old_strb  current line contents and valid-byte mask
//   new_data/new_strb  incoming store data and byte enables
//   merged_data        old bytes replaced wherever new_strb is set
//   merged_strb        old_strb | new_strb
module dcache_wbuf_byte_merge #(
    parameter int LINE_W = 128
) (
    input  logic [LINE_W-1:0]   old_data,
    input  logic [LINE_W/8-1:0] old_strb,
    input  logic [LINE_W-1:0]   new_data,
    input  logic [LINE_W/8-1:0] new_strb,
    output logic [LINE_W-1:0]   merged_data,
    output logic [LINE_W/8-1:0] merged_strb
);

    // Per-byte select between the stored and the incoming byte.
    always_comb begin
        merged_data = old_data;
        for (int b = 0; b < LINE_W / 8; b++) begin
            merged_data[b*8 +: 8] = new_strb[b] ? new_data[b*8 +: 8] : old_data[b*8 +: 8];
        end
        merged_strb = old_strb | new_strb;
    end

endmodule

// File: rtl/dcache_wbuf.sv
// Line-granular data-cache write buffer.
// Holds up to DEPTH dirty lines, merges stores to a buffered line, forwards
// buffered data to loads and drains the oldest line to the AXI write master.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cpu_wreq_i/awaddr/wdata/wstrb    store-line request; cpu_wready_o accepts it
//   cpu_rreq_i/araddr                load lookup; read_hit_o/cpu_rdata_o/cpu_rstrb_o
//                                    answer one cycle later
//   flush_i, flush_done_o            drain request and its completion flag
//   count_o, full_o, empty_o         occupancy
//   axi_*                            head-of-queue write request and response
module dcache_wbuf
    import dcache_wbuf_pkg::*;
#(
    parameter int DEPTH  = DCACHE_WBUF_DEPTH,
    parameter int LINE_W = DCACHELINE_WIDTH,
    parameter int ADDR_W = WBUF_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_wreq_i,
    input  logic [ADDR_W-1:0]         cpu_awaddr_i,
    input  logic [LINE_W-1:0]         cpu_wdata_i,
    input  logic [LINE_W/8-1:0]       cpu_wstrb_i,
    output logic                      cpu_wready_o,
    input  logic                      cpu_rreq_i,
    input  logic [ADDR_W-1:0]         cpu_araddr_i,
    output logic                      read_hit_o,
    output logic [LINE_W-1:0]         cpu_rdata_o,
    output logic [LINE_W/8-1:0]       cpu_rstrb_o,
    input  logic                      flush_i,
    output logic                      flush_done_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      axi_wen_o,
    output logic [ADDR_W-1:0]         axi_awaddr_o,
    output logic [LINE_W-1:0]         axi_wdata_o,
    output logic [LINE_W/8-1:0]       axi_wstrb_o,
    input  logic                      axi_req_accept_i,
    input  logic                      axi_bvalid_i
);

    localparam int OFFS_W = $clog2(LINE_W / 8);
    localparam int TAG_W  = ADDR_W - OFFS_W;
    localparam int STRB_W = LINE_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [STRB_W-1:0] strb_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    drain_state_e      state;
    drain_state_e      state_nxt;

    logic [TAG_W-1:0]  wtag;
    logic [TAG_W-1:0]  rtag;
    logic              in_flight;
    logic              whit;
    logic [PTR_W-1:0]  widx;
    logic              young_hit;
    logic [PTR_W-1:0]  young_idx;
    logic              old_hit;
    logic              rhit;
    logic [PTR_W-1:0]  ridx;
    logic              strb_zero;
    logic              full;
    logic              empty;
    logic              accept;
    logic              do_merge;
    logic              do_alloc;
    logic              pop;
    logic [CNT_W-1:0]  count_nxt;
    logic [LINE_W-1:0] merged_data;
    logic [STRB_W-1:0] merged_strb;

    assign wtag      = cpu_awaddr_i[ADDR_W-1:OFFS_W];
    assign rtag      = cpu_araddr_i[ADDR_W-1:OFFS_W];
    assign in_flight = (state != ST_IDLE);
    assign strb_zero = (cpu_wstrb_i == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

    // Store lookup: the in-flight head is never a merge target, so at most
    // one entry can match here.
    always_comb begin
        whit = 1'b0;
        widx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            whit = whit | (valid_q[i] && (tag_q[i] == wtag) && !(in_flight && (PTR_W'(i) == head)));
            widx = (valid_q[i] && (tag_q[i] == wtag) && !(in_flight && (PTR_W'(i) == head))) ? PTR_W'(i) : widx;
        end
    end

    // Load lookup: a non-in-flight match is always younger than the in-flight
    // head, so it takes priority; the head only supplies when alone.
    always_comb begin
        young_hit = 1'b0;
        young_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            young_hit = young_hit | (valid_q[i] && (tag_q[i] == rtag) && !(in_flight && (PTR_W'(i) == head)));
            young_idx = (valid_q[i] && (tag_q[i] == rtag) && !(in_flight && (PTR_W'(i) == head))) ? PTR_W'(i) : young_idx;
        end
        old_hit = in_flight && valid_q[head] && (tag_q[head] == rtag);
        rhit    = young_hit | old_hit;
        ridx    = young_hit ? young_idx : head;
    end

    // A full buffer still accepts merges and empty-strobe stores.
    assign cpu_wready_o = ~rst & (strb_zero | whit | ~full);
    assign accept       = cpu_wreq_i & cpu_wready_o;
    assign do_merge     = accept & whit & ~strb_zero;
    assign do_alloc     = accept & ~whit & ~strb_zero;
    assign pop          = (state == ST_WAIT_B) & axi_bvalid_i;

    dcache_wbuf_byte_merge #(.LINE_W(LINE_W)) u_merge (
        .old_data    (data_q[widx]),
        .old_strb    (strb_q[widx]),
        .new_data    (cpu_wdata_i),
        .new_strb    (cpu_wstrb_i),
        .merged_data (merged_data),
        .merged_strb (merged_strb)
    );

    // Occupancy update from allocation and pop in the same cycle.
    always_comb begin
        case ({do_alloc, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Entry storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                strb_q[i] <= '0;
            end
            valid_q <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (do_merge) begin
                data_q[widx] <= merged_data;
                strb_q[widx] <= merged_strb;
            end else if (do_alloc) begin
                tag_q[tail]   <= wtag;
                data_q[tail]  <= cpu_wdata_i;
                strb_q[tail]  <= cpu_wstrb_i;
                valid_q[tail] <= 1'b1;
                tail          <= tail + PTR_W'(1);
            end
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            count <= count_nxt;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Drain FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = empty ? ST_IDLE : ST_REQ;
            ST_REQ:    state_nxt = axi_req_accept_i ? ST_WAIT_B : ST_REQ;
            ST_WAIT_B: state_nxt = axi_bvalid_i ? ST_IDLE : ST_WAIT_B;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Registered load-forwarding result.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_hit_o  <= 1'b0;
            cpu_rdata_o <= '0;
            cpu_rstrb_o <= '0;
        end else if (cpu_rreq_i && rhit) begin
            read_hit_o  <= 1'b1;
            cpu_rdata_o <= data_q[ridx];
            cpu_rstrb_o <= strb_q[ridx];
        end else begin
            read_hit_o  <= 1'b0;
            cpu_rdata_o <= '0;
            cpu_rstrb_o <= '0;
        end
    end

    assign axi_wen_o    = (state == ST_REQ);
    assign axi_awaddr_o = {tag_q[head], {OFFS_W{1'b0}}};
    assign axi_wdata_o  = data_q[head];
    assign axi_wstrb_o  = strb_q[head];

    assign count_o      = count;
    assign full_o       = full;
    assign empty_o      = empty;
    assign flush_done_o = flush_i & empty & (state == ST_IDLE);

endmodule
